bullet_pool: RTL and testbench

//  Player-bullet manager for the shooter game. Holds a fixed pool of bullet slots,

---
 rtl/plane_game_pkg.sv | 17 +
 rtl/bullet_slot.sv | 62 ++++++
 rtl/bullet_pool.sv | 151 +++++++++++++++
 tb/tb_bullet_pool.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/plane_game_pkg.sv
// Shared types and screen constants for the plane, enemy, boss and bullet stages.
package plane_game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PLANE_W  = 48;

  typedef logic [9:0]  coord_t;
  typedef logic [11:0] rgb_t;

  // Row just above an object of height h at row py, clamped to the screen top.
  function automatic coord_t row_above(input coord_t py, input coord_t h);
    if (py < h) return '0;
    return py - h;
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: valid/position registers, upward move with top-of-screen
// retirement, and the 11-bit pixel coverage compare.
module bullet_slot
  import plane_game_pkg::*;
#(
  parameter int BULLET_W = 4,
  parameter int BULLET_H = 10,
  parameter int SPEED    = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   move_tick,
  input  logic   kill,
  input  logic   spawn,
  input  coord_t spawn_x,
  input  coord_t spawn_y,
  input  coord_t x,
  input  coord_t y,
  output logic   valid,
  output logic   retiring,
  output logic   hit
);

  logic   valid_reg;
  coord_t bx_reg;
  coord_t by_reg;

  assign valid    = valid_reg;
  assign retiring = valid_reg && (by_reg < coord_t'(SPEED));

  // Widened compare so a bullet at the right/bottom edge cannot wrap to 0.
  logic [10:0] x_ext, y_ext, bx_ext, by_ext;
  assign x_ext  = {1'b0, x};
  assign y_ext  = {1'b0, y};
  assign bx_ext = {1'b0, bx_reg};
  assign by_ext = {1'b0, by_reg};

  assign hit = valid_reg
            && (x_ext >= bx_ext) && (x_ext < bx_ext + 11'(BULLET_W))
            && (y_ext >= by_ext) && (y_ext < by_ext + 11'(BULLET_H));

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      bx_reg    <= '0;
      by_reg    <= '0;
    end else if (kill) begin
      valid_reg <= 1'b0;
    end else if (move_tick) begin
      if (spawn) begin
        valid_reg <= 1'b1;
        bx_reg    <= spawn_x;
        by_reg    <= spawn_y;
      end else if (retiring) begin
        valid_reg <= 1'b0;
      end else if (valid_reg) begin
        by_reg <= by_reg - coord_t'(SPEED);
      end
    end
  end

endmodule

// File: rtl/bullet_pool.sv
// Player bullet pool: N_SLOTS bullet_slot instances, free-slot allocation, shot
// cooldown and registered pixel query. Define BULLET_DOUBLE_SHOT_EN for twin shots.
module bullet_pool
  import plane_game_pkg::*;
#(
  parameter int   N_SLOTS    = 8,
  parameter int   BULLET_W   = 4,
  parameter int   BULLET_H   = 10,
  parameter int   SPEED      = 4,
  parameter int   COOLDOWN   = 8,
  parameter rgb_t BULLET_RGB = 12'hFF0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               move_tick,
  input  logic               fire,
  input  coord_t             plane_x,
  input  coord_t             plane_y,
  input  coord_t             x,
  input  coord_t             y,
  input  logic               kill_valid,
  input  logic [3:0]         kill_idx,
  output logic               bullet_en,
  output rgb_t               bullet_rgb,
  output logic [3:0]         hit_idx,
  output logic [N_SLOTS-1:0] live_mask
);

  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  logic [N_SLOTS-1:0] valid_vec, retiring_vec, hit_vec, spawn_vec, free_vec;
  coord_t             slot_x [N_SLOTS];
  coord_t             centre_x, spawn_y;
  logic [CD_W-1:0]    cooldown_reg;

  assign centre_x  = plane_x + coord_t'(PLANE_W / 2 - BULLET_W / 2);
  assign spawn_y   = row_above(plane_y, coord_t'(BULLET_H));
  assign free_vec  = ~valid_vec | retiring_vec;
  assign live_mask = valid_vec;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      bullet_slot #(
        .BULLET_W(BULLET_W),
        .BULLET_H(BULLET_H),
        .SPEED   (SPEED)
      ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .move_tick(move_tick),
        .kill     (kill_valid && (kill_idx == 4'(gi))),
        .spawn    (spawn_vec[gi]),
        .spawn_x  (slot_x[gi]),
        .spawn_y  (spawn_y),
        .x        (x),
        .y        (y),
        .valid    (valid_vec[gi]),
        .retiring (retiring_vec[gi]),
        .hit      (hit_vec[gi])
      );
    end
  endgenerate

  // Two lowest free slots, counting slots that retire on this tick as free.
  logic       first_found, second_found, accept;
  logic [3:0] first_idx, second_idx;

  always_comb begin
    first_found  = 1'b0;
    second_found = 1'b0;
    first_idx    = '0;
    second_idx   = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (free_vec[i]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = 4'(i);
        end else if (!second_found) begin
          second_found = 1'b1;
          second_idx   = 4'(i);
        end
      end
    end
  end

  assign accept = move_tick && fire && (cooldown_reg == '0) && first_found;

  always_comb begin
    spawn_vec = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      slot_x[i] = centre_x;
    end
    if (accept) begin
      for (int i = 0; i < N_SLOTS; i++) begin
`ifdef BULLET_DOUBLE_SHOT_EN
        if (second_found && (4'(i) == first_idx)) begin
          spawn_vec[i] = 1'b1;
          slot_x[i]    = plane_x + 10'd8;
        end else if (second_found && (4'(i) == second_idx)) begin
          spawn_vec[i] = 1'b1;
          slot_x[i]    = plane_x + coord_t'(PLANE_W - 8 - BULLET_W);
        end else if (!second_found && (4'(i) == first_idx)) begin
          spawn_vec[i] = 1'b1;
        end
`else
        if (4'(i) == first_idx) begin
          spawn_vec[i] = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cooldown_reg <= '0;
    end else if (accept) begin
      cooldown_reg <= CD_W'(COOLDOWN);
    end else if (move_tick && (cooldown_reg != '0)) begin
      cooldown_reg <= cooldown_reg - CD_W'(1);
    end
  end

  logic       hit_any;
  logic [3:0] hit_lowest;

  always_comb begin
    hit_any    = 1'b0;
    hit_lowest = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any    = 1'b1;
        hit_lowest = 4'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bullet_en  <= 1'b0;
      bullet_rgb <= '0;
      hit_idx    <= '0;
    end else begin
      bullet_en  <= hit_any;
      bullet_rgb <= hit_any ? BULLET_RGB : rgb_t'(0);
      hit_idx    <= hit_lowest;
    end
  end

endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench for bullet_pool: queries push expected pixel/live responses,
// a monitor pops and compares one clock later.
module tb_bullet_pool;

  logic        clk = 1'b0;
  logic        rst;
  logic        move_tick, fire, kill_valid;
  logic [9:0]  plane_x, plane_y, x, y;
  logic [3:0]  kill_idx;
  logic        bullet_en;
  logic [11:0] bullet_rgb;
  logic [3:0]  hit_idx;
  logic [7:0]  live_mask;

  bullet_pool dut (
    .clk       (clk),
    .rst       (rst),
    .move_tick (move_tick),
    .fire      (fire),
    .plane_x   (plane_x),
    .plane_y   (plane_y),
    .x         (x),
    .y         (y),
    .kill_valid(kill_valid),
    .kill_idx  (kill_idx),
    .bullet_en (bullet_en),
    .bullet_rgb(bullet_rgb),
    .hit_idx   (hit_idx),
    .live_mask (live_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       en;
    logic [11:0] rgb;
    logic [3:0] idx;
    logic [7:0] live;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   passed = 0;
  logic qv = 1'b0;
  logic qv_d = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  always @(posedge clk) qv_d <= qv;

  always @(negedge clk) begin
    if (qv_d) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        cur = sb.pop_front();
        chk({cur.name, ".en"},   32'(bullet_en),  32'(cur.en));
        chk({cur.name, ".rgb"},  32'(bullet_rgb), 32'(cur.rgb));
        chk({cur.name, ".idx"},  32'(hit_idx),    32'(cur.idx));
        chk({cur.name, ".live"}, 32'(live_mask),  32'(cur.live));
        $display("query %s: en=%0b rgb=%03h idx=%0d live=%02h", cur.name,
                 bullet_en, bullet_rgb, hit_idx, live_mask);
      end
    end
  end

  task automatic query(input string nm, input int qx, input int qy,
                       input logic e, input logic [3:0] id, input logic [7:0] lv);
    exp_t t;
    t.name = nm;
    t.en   = e;
    t.rgb  = e ? 12'hFF0 : 12'h000;
    t.idx  = id;
    t.live = lv;
    sb.push_back(t);
    x  = qx[9:0];
    y  = qy[9:0];
    qv = 1'b1;
    @(posedge clk); #1;
    qv = 1'b0;
  endtask

  task automatic tick();
    move_tick = 1'b1;
    @(posedge clk); #1;
    move_tick = 1'b0;
  endtask

  task automatic kill(input logic [3:0] k, input logic with_tick);
    kill_valid = 1'b1;
    kill_idx   = k;
    move_tick  = with_tick;
    @(posedge clk); #1;
    kill_valid = 1'b0;
    move_tick  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; fire = 1'b0; move_tick = 1'b0; kill_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; move_tick = 1'b0; fire = 1'b0; kill_valid = 1'b0; kill_idx = '0;
    plane_x = 10'd300; plane_y = 10'd400; x = '0; y = '0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    query("reset", 0, 0, 1'b0, 4'd0, 8'h00);

`ifndef BULLET_DOUBLE_SHOT_EN
    // First shot and pixel extents of slot0 at (322,390)
    fire = 1'b1;
    tick();
    query("spawn_hit",   322, 390, 1'b1, 4'd0, 8'h01);
    query("spawn_corner",325, 399, 1'b1, 4'd0, 8'h01);
    query("right_miss",  326, 390, 1'b0, 4'd0, 8'h01);
    query("below_miss",  322, 400, 1'b0, 4'd0, 8'h01);
    query("left_miss",   321, 389, 1'b0, 4'd0, 8'h01);

    // Autofire: spawns on ticks 0, 9, 18 only
    for (int i = 1; i < 20; i++) tick();
    query("slot0_314",   322, 314, 1'b1, 4'd0, 8'h07);
    query("slot1_350",   322, 350, 1'b1, 4'd1, 8'h07);
    query("slot2_386",   322, 386, 1'b1, 4'd2, 8'h07);
    query("above_0",     322, 313, 1'b0, 4'd0, 8'h07);

    // Spawn clamped to row 0, then reset clears it mid-flight
    do_reset();
    plane_y = 10'd5; fire = 1'b1;
    tick();
    fire = 1'b0;
    query("clamp_top",   322, 0,   1'b1, 4'd0, 8'h01);
    query("clamp_bot",   322, 9,   1'b1, 4'd0, 8'h01);
    query("clamp_miss",  322, 10,  1'b0, 4'd0, 8'h01);
    do_reset();
    query("midreset",    322, 0,   1'b0, 4'd0, 8'h00);

    // Bullet at by=3 retires without wrapping
    plane_y = 10'd13; fire = 1'b1;
    tick();
    fire = 1'b0;
    query("by3_hit",     322, 12,  1'b1, 4'd0, 8'h01);
    tick();
    query("retired",     322, 3,   1'b0, 4'd0, 8'h00);
    query("no_wrap",     322, 1023,1'b0, 4'd0, 8'h00);

    // Right edge: bx=1022 must not wrap onto x=0
    do_reset();
    plane_x = 10'd1000; plane_y = 10'd400; fire = 1'b1;
    tick();
    fire = 1'b0;
    query("edge_hit",    1023, 390, 1'b1, 4'd0, 8'h01);
    query("edge_nowrap", 0,    390, 1'b0, 4'd0, 8'h01);

    // Kill beats a spawn into the same slot
    do_reset();
    plane_x = 10'd300; fire = 1'b1;
    kill(4'd0, 1'b1);
    query("kill_spawn",  322, 390, 1'b0, 4'd0, 8'h00);

    // Fill the pool, keep firing, free slot 5
    do_reset();
    fire = 1'b1;
    for (int i = 0; i <= 80; i++) tick();
    query("full",        322, 70,  1'b1, 4'd0, 8'hFF);
    kill(4'd5, 1'b0);
    query("kill5",       0,   0,   1'b0, 4'd0, 8'hDF);
    tick();
    query("respawn5",    322, 390, 1'b1, 4'd5, 8'hFF);
    kill(4'd9, 1'b0);
    query("kill_oor",    0,   0,   1'b0, 4'd0, 8'hFF);
    fire = 1'b0;
    kill(4'd0, 1'b1);
    query("kill_move",   322, 66,  1'b0, 4'd0, 8'hFE);
`else
    // Twin shot from plane_x=300: bx=308 and bx=336
    fire = 1'b1;
    tick();
    fire = 1'b0;
    query("twin_left",   308, 390, 1'b1, 4'd0, 8'h03);
    query("twin_left_r", 311, 399, 1'b1, 4'd0, 8'h03);
    query("twin_gap",    312, 390, 1'b0, 4'd0, 8'h03);
    query("twin_centre", 322, 390, 1'b0, 4'd0, 8'h03);
    query("twin_right",  336, 390, 1'b1, 4'd1, 8'h03);
    query("twin_right_r",339, 390, 1'b1, 4'd1, 8'h03);
    query("twin_edge",   340, 390, 1'b0, 4'd0, 8'h03);

    // Kill on slot0 beats its spawn; slot1 still gets its bullet
    do_reset();
    fire = 1'b1;
    kill(4'd0, 1'b1);
    fire = 1'b0;
    query("kill_spawn",  336, 390, 1'b1, 4'd1, 8'h02);
    query("kill_spawn0", 308, 390, 1'b0, 4'd0, 8'h02);
`endif

    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
